tti_uart_rx: RTL
================

Name: tti_uart_rx

Overview:
- Serial teletype line receiver directly upstream of the DJS-130 teletype input device.
- Deserializes an asynchronous 8-bit start/stop frame from the keyboard line and presents the byte on o_data.
- Presents the byte together with a one-cycle active-low write strobe, matching the active-low i_write/i_data pair the TTI top consumes.
- Flags framing and parity errors. Provides no back-pressure: the TTI latches on the strobe.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 110: line rate. Teletype default; legal up to CLK_HZ/32.
- PARITY, 0: 0 = none, 1 = odd, 2 = even, 3 = mark (parity bit must be 1).
- DIV, CLK_HZ/(BAUD*16): derived localparam. Clocks per 1/16-bit tick, integer floor, minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_rxd  in  1  serial line, idle high (mark), asynchronous to clk.
- o_data  out  8  last received byte, LSB = first data bit; held until the next good frame.
- o_write_n  out  1  active-low, exactly one clk wide, asserted when o_data is updated.
- o_frame_err  out  1  sticky per frame: stop bit sampled low on the last frame.
- o_par_err  out  1  parity mismatch on the last frame (0 when PARITY=0).
- o_busy  out  1  high from validated start edge until return to IDLE.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: o_data=8'h00, o_write_n=1, o_frame_err=0, o_par_err=0, o_busy=0, state=IDLE. The synchronizer flops reset to 1 (mark), so reset cannot create a false start.
- Input sync: i_rxd passes through 2 flops; all logic uses the synchronized bit rxs. This adds 2 clk of latency.
- Tick generator: a counter runs 0..DIV-1 and pulses tick at DIV-1. It is forced to 0 on start detection so sampling phase is edge-aligned.
- Sample counter: scnt (4 bits) counts ticks within a bit. Data is sampled when scnt==7 (mid-bit). A bit ends when scnt wraps 15->0.
- IDLE:
  - On rxs 1->0, clear the tick counter and scnt, set o_busy=1, go to START.
- START:
  - At mid-bit, if rxs==1 it is a glitch: o_busy=0, return to IDLE with no flags changed.
  - If rxs==0 at mid-bit, continue; at bit end go to DATA with bit index 0.
- DATA:
  - At mid-bit, shift rxs into the MSB of the shift register (shift right).
  - After index 7 ends, go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - At mid-bit, compare rxs against the expected value: odd -> ^data==~rxs; even -> ^data==rxs; mark -> rxs==1.
  - Latch the mismatch into a pending flag, then go to STOP at bit end.
- STOP: evaluated at mid-bit (no wait for bit end, which tolerates short stop bits and back-to-back frames).
  - If rxs==1:
    - o_data<=shift register and o_write_n<=0 for one clk.
    - o_frame_err<=0 and o_par_err<=pending.
    - o_busy<=0, go to IDLE.
  - If rxs==0:
    - o_frame_err<=1, no strobe, o_data unchanged, o_par_err<=pending.
    - Go to BREAK.
- BREAK: hold o_busy=1 until rxs==1, then o_busy=0 and go to IDLE. A held-low line (break) produces exactly one framing error and no bytes.
- Latency: o_write_n falls mid-stop-bit, i.e. about 9.5 (no parity) or 10.5 bit times plus 2-3 clk after the start edge.
- Reset mid-frame: returns to IDLE immediately. A partial frame is discarded with no strobe.
- A falling edge during START/DATA/PARITY/STOP is ignored; only the IDLE state arms on an edge.

Decomposition:
- Package tti_uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP, BREAK};
  - parity mode constants PAR_NONE/ODD/EVEN/MARK;
  - constants OVS=16 and MID=7.
- One sub-module, tti_baud_tick (params DIV; ports clk, rst_n, i_clr, o_tick), instantiated once. The FSM, shifter and flags stay in tti_uart_rx.

Test Plan:
- Bench parameters CLK_HZ=640000, BAUD=10000 (DIV=4, 64 clk/bit), PARITY=0:
  - Send 0x55 with a 1-bit stop -> one o_write_n low pulse of 1 clk, o_data=8'h55, o_frame_err=0, strobe about 610 clk after the start edge.
  - Drive a 20-clk low glitch from idle -> no strobe, o_busy pulses high then 0 within 33 clk, o_data unchanged.
  - Send 0x41 with the stop bit low, then hold the line low for 3 frames -> o_frame_err=1, no strobe, o_busy stays 1 until the line rises, then the next 0x0D frame strobes o_data=8'h0D with o_frame_err=0.
  - Send 0x41, 0x42, 0x43 back-to-back with a 1-bit stop -> exactly 3 strobes, data in order.
- PARITY=1 (odd):
  - Send 0x07 with parity bit 0 -> strobe, o_data=8'h07, o_par_err=0.
  - Repeat with parity bit 1 -> strobe, o_par_err=1.
- Assert rst_n low during data bit 4 of 0xFF, release, then send 0x12 -> no strobe for the partial frame, o_data=8'h12 after the second frame, all flags 0.

Source files
------------

// File: rtl/tti_uart_pkg.sv
// Shared types and constants for the teletype serial line receiver.
package tti_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    localparam int PAR_MARK = 3;

    localparam int OVS = 16;
    localparam int MID = 7;

endpackage

// File: rtl/tti_uart_rx_if.sv
// Received-byte bus from the line receiver to the TTI device (active-low write strobe).
interface tti_uart_rx_if;

    logic [7:0] data;
    logic       write_n;
    logic       frame_err;
    logic       par_err;
    logic       busy;

    modport master (output data, write_n, frame_err, par_err, busy);
    modport slave  (input  data, write_n, frame_err, par_err, busy);

endinterface

// File: rtl/tti_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks, re-phased by i_clr.
module tti_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (i_clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // A clear wins over a coincident terminal count so the new phase starts clean.
    assign o_tick = (cnt == LAST) && !i_clr;

endmodule

// File: rtl/tti_uart_rx.sv
// Start/stop serial receiver feeding the TTI device: 16x oversampling, mid-bit sampling,
// optional parity, framing-error and break handling.
module tti_uart_rx
    import tti_uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 110,
    parameter int PARITY = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_rxd,
    tti_uart_rx_if.master bus
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    state_t     state, state_n;
    logic       rx_meta, rxs, rxs_prev;
    logic       tick, clr;
    logic [3:0] scnt, scnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shreg, shreg_n;
    logic       pend, pend_n;
    logic [7:0] data_r, data_n;
    logic       write_n_r, write_n_n;
    logic       ferr_r, ferr_n;
    logic       perr_r, perr_n;
    logic       busy_r, busy_n;
    logic       mid, bit_end, par_mismatch;

    tti_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (clr),
        .o_tick (tick)
    );

    // Synchronizer and edge-history flops idle at mark so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= i_rxd;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            scnt      <= '0;
            idx       <= '0;
            shreg     <= '0;
            pend      <= 1'b0;
            data_r    <= 8'h00;
            write_n_r <= 1'b1;
            ferr_r    <= 1'b0;
            perr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state     <= state_n;
            scnt      <= scnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            pend      <= pend_n;
            data_r    <= data_n;
            write_n_r <= write_n_n;
            ferr_r    <= ferr_n;
            perr_r    <= perr_n;
            busy_r    <= busy_n;
        end
    end

    assign mid     = tick && (scnt == 4'(MID));
    assign bit_end = tick && (scnt == 4'(OVS - 1));

    always_comb begin
        par_mismatch = 1'b0;
        if (PARITY == PAR_ODD)
            par_mismatch = (rxs == ^shreg);
        else if (PARITY == PAR_EVEN)
            par_mismatch = (rxs != ^shreg);
        else if (PARITY == PAR_MARK)
            par_mismatch = !rxs;
    end

    // Stop is judged at mid-bit so short stop bits and back-to-back frames are accepted.
    always_comb begin
        state_n   = state;
        scnt_n    = tick ? scnt + 4'd1 : scnt;
        idx_n     = idx;
        shreg_n   = shreg;
        pend_n    = pend;
        data_n    = data_r;
        write_n_n = 1'b1;
        ferr_n    = ferr_r;
        perr_n    = perr_r;
        busy_n    = busy_r;
        clr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    clr     = 1'b1;
                    scnt_n  = '0;
                    pend_n  = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (mid && rxs) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (bit_end) begin
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (mid)
                    shreg_n = {rxs, shreg[7:1]};
                if (bit_end) begin
                    if (idx == 3'd7)
                        state_n = (PARITY != PAR_NONE) ? tti_uart_pkg::PARITY : STOP;
                    else
                        idx_n = idx + 3'd1;
                end
            end
            tti_uart_pkg::PARITY: begin
                if (mid)
                    pend_n = par_mismatch;
                if (bit_end)
                    state_n = STOP;
            end
            STOP: begin
                if (mid) begin
                    perr_n = pend;
                    if (rxs) begin
                        data_n    = shreg;
                        write_n_n = 1'b0;
                        ferr_n    = 1'b0;
                        busy_n    = 1'b0;
                        state_n   = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data      = data_r;
    assign bus.write_n   = write_n_r;
    assign bus.frame_err = ferr_r;
    assign bus.par_err   = perr_r;
    assign bus.busy      = busy_r;

endmodule
